// File: rtl/gen3_framing_pkg.sv
// gen3_framing_pkg: tx_type classes, framing tokens and scheduler states shared with the byte checker
package gen3_framing_pkg;
  localparam logic [5:0] TY_NONE      = 6'b000000;
  localparam logic [5:0] TY_DATA      = 6'b100000;
  localparam logic [5:0] TY_TLPSTART  = 6'b010000;
  localparam logic [5:0] TY_TLPEND    = 6'b001000;
  localparam logic [5:0] TY_DLLPEND   = 6'b000100;
  localparam logic [5:0] TY_DLLPSTART = 6'b000010;
  localparam logic [5:0] TY_TLPEDB    = 6'b000001;
  localparam logic [3:0] STP_NIB      = 4'hF;
  localparam logic [7:0] SDP_B0       = 8'hF0;
  localparam logic [7:0] SDP_B1       = 8'h53;
  localparam logic [7:0] END_B        = 8'h1F;
  localparam logic [7:0] EDB_B        = 8'hC0;
  typedef enum logic [3:0] {
    IDLE, STP1, STP2, STP3, STP4, TLP_DATA, TLP_END, SDP1, SDP2, DLLP_DATA, DLLP_TAIL
  } state_t;
endpackage

// File: rtl/gen3_rr_arbiter.sv
// gen3_rr_arbiter: two-requester round-robin (a = TLP, b = DLLP) with strict-priority override for b
module gen3_rr_arbiter (
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  input  logic last_b,
  input  logic prio_b,
  output logic gnt_a,
  output logic gnt_b
);
  assign gnt_a = en & req_a & (~req_b | (~prio_b & last_b));
  assign gnt_b = en & req_b & ~gnt_a;
endmodule

// File: rtl/gen3_tx_framer.sv
// gen3_tx_framer: Gen3 TX framing scheduler; define GEN3_TX_DLLP_PRIORITY_EN to give DLLPs strict priority
module gen3_tx_framer
  import gen3_framing_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE  = 8'h00,
  parameter int         DLLP_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       tlp_req,
  input  logic [9:0] tlp_len_dw,
  input  logic [11:0] tlp_seq,
  input  logic [7:0] tlp_data,
  input  logic       tlp_bad,
  output logic       tlp_gnt,
  output logic       tlp_rd,
  input  logic       dllp_req,
  input  logic [7:0] dllp_data,
  output logic       dllp_gnt,
  output logic       dllp_rd,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic [1:0] tx_sync,
  output logic [5:0] tx_type
);
  localparam logic [11:0] DLIM = 12'(DLLP_BYTES);
`ifdef GEN3_TX_DLLP_PRIORITY_EN
  localparam logic PRIO = 1'b1;
`else
  localparam logic PRIO = 1'b0;
`endif
  state_t      state, ns, es;
  logic [11:0] cnt, cnt_n;
  logic        last_b, last_n;
  logic [9:0]  len_q;
  logic [11:0] seq_q;
  logic [7:0]  d_data;
  logic [5:0]  d_type;
  logic        d_valid;

  gen3_rr_arbiter u_arb (
    .en    (rst & tx_en & (state == IDLE)),
    .req_a (tlp_req),
    .req_b (dllp_req),
    .last_b(last_b),
    .prio_b(PRIO),
    .gnt_a (tlp_gnt),
    .gnt_b (dllp_gnt)
  );

  // the grant cycle is itself the first token slot, so back-to-back packets leave no gap
  assign es = tlp_gnt ? STP1 : dllp_gnt ? SDP1 : state;

  // next state, counter, source pops and the byte to emit next cycle
  always_comb begin
    ns      = state;
    cnt_n   = cnt;
    last_n  = last_b;
    d_data  = IDLE_BYTE;
    d_type  = TY_NONE;
    tlp_rd  = 1'b0;
    dllp_rd = 1'b0;
    d_valid = rst & tx_en & (es != IDLE);
    if (rst && tx_en) begin
      case (es)
        STP1: begin
          d_data = {tlp_len_dw[3:0], STP_NIB};
          last_n = 1'b0;
          ns     = STP2;
        end
        STP2: begin
          d_data = {2'b00, len_q[9:4]};
          ns     = STP3;
        end
        STP3: begin
          d_data = {4'h0, seq_q[11:8]};
          ns     = STP4;
        end
        STP4: begin
          d_data = seq_q[7:0];
          d_type = TY_TLPSTART;
          cnt_n  = '0;
          ns     = (len_q == '0) ? TLP_END : TLP_DATA;
        end
        TLP_DATA: begin
          d_data = tlp_data;
          d_type = TY_DATA;
          tlp_rd = 1'b1;
          cnt_n  = cnt + 12'd1;
          ns     = (cnt_n == {len_q, 2'b00}) ? TLP_END : TLP_DATA;
        end
        TLP_END: begin
          d_data = tlp_bad ? EDB_B : END_B;
          d_type = tlp_bad ? TY_TLPEDB : TY_TLPEND;
          ns     = IDLE;
        end
        SDP1: begin
          d_data = SDP_B0;
          last_n = 1'b1;
          ns     = SDP2;
        end
        SDP2: begin
          d_data = SDP_B1;
          d_type = TY_DLLPSTART;
          cnt_n  = '0;
          ns     = DLLP_DATA;
        end
        DLLP_DATA: begin
          d_data  = dllp_data;
          d_type  = TY_DATA;
          dllp_rd = 1'b1;
          cnt_n   = cnt + 12'd1;
          ns      = (cnt_n == DLIM) ? DLLP_TAIL : DLLP_DATA;
        end
        DLLP_TAIL: begin
          d_data = IDLE_BYTE;
          d_type = TY_DLLPEND;
          ns     = IDLE;
        end
        default: ;
      endcase
    end
  end

  // state, latched packet fields and registered lane outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last_b   <= 1'b1;
      len_q    <= '0;
      seq_q    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_sync  <= 2'b00;
      tx_type  <= TY_NONE;
    end else begin
      state    <= ns;
      cnt      <= cnt_n;
      last_b   <= last_n;
      len_q    <= tlp_gnt ? tlp_len_dw : len_q;
      seq_q    <= tlp_gnt ? tlp_seq : seq_q;
      tx_data  <= d_data;
      tx_valid <= d_valid;
      tx_sync  <= {d_valid, 1'b0};
      tx_type  <= d_type;
    end
  end
endmodule

// File: tb/tb_gen3_tx_framer.sv
// tb_gen3_tx_framer: directed and random checks of the framer against a packet-level byte-list model
module tb_gen3_tx_framer;
`ifdef GEN3_TX_DLLP_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  typedef struct packed {
    logic [7:0] d;
    logic [5:0] t;
    logic       rt;
    logic       rd;
  } ent_t;

  logic clk, rst, tx_en, tlp_req, tlp_bad, tlp_gnt, tlp_rd, dllp_req, dllp_gnt, dllp_rd, tx_valid;
  logic [9:0] tlp_len_dw;
  logic [11:0] tlp_seq;
  logic [7:0] tlp_data, dllp_data, tx_data;
  logic [1:0] tx_sync;
  logic [5:0] tx_type;

  ent_t cur[$];
  logic [7:0] tq[$], dq[$];
  int gq[$];
  int n_chk, n_fail, nrt, nrd;
  bit model_last, pay_fixed, m_gt, m_gd;

  gen3_tx_framer dut (
    .clk(clk), .rst(rst), .tx_en(tx_en),
    .tlp_req(tlp_req), .tlp_len_dw(tlp_len_dw), .tlp_seq(tlp_seq), .tlp_data(tlp_data),
    .tlp_bad(tlp_bad), .tlp_gnt(tlp_gnt), .tlp_rd(tlp_rd),
    .dllp_req(dllp_req), .dllp_data(dllp_data), .dllp_gnt(dllp_gnt), .dllp_rd(dllp_rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_sync(tx_sync), .tx_type(tx_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic [7:0] d, input logic [5:0] t, input logic rt, input logic rd);
    ent_t e;
    e.d = d; e.t = t; e.rt = rt; e.rd = rd;
    return e;
  endfunction

  task automatic build_tlp();
    logic [9:0] l;
    logic [7:0] b;
    l = tlp_len_dw;
    cur.push_back(mk({l[3:0], 4'hF}, 6'b000000, 1'b0, 1'b0));
    cur.push_back(mk({2'b00, l[9:4]}, 6'b000000, 1'b0, 1'b0));
    cur.push_back(mk({4'h0, tlp_seq[11:8]}, 6'b000000, 1'b0, 1'b0));
    cur.push_back(mk(tlp_seq[7:0], 6'b010000, 1'b0, 1'b0));
    for (int i = 0; i < 4 * int'(l); i++) begin
      b = pay_fixed ? 8'(i + 1) : 8'($urandom);
      tq.push_back(b);
      cur.push_back(mk(b, 6'b100000, 1'b1, 1'b0));
    end
    cur.push_back(tlp_bad ? mk(8'hC0, 6'b000001, 1'b0, 1'b0) : mk(8'h1F, 6'b001000, 1'b0, 1'b0));
  endtask

  task automatic build_dllp();
    logic [7:0] b;
    cur.push_back(mk(8'hF0, 6'b000000, 1'b0, 1'b0));
    cur.push_back(mk(8'h53, 6'b000010, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      dq.push_back(b);
      cur.push_back(mk(b, 6'b100000, 1'b0, 1'b1));
    end
    cur.push_back(mk(8'h00, 6'b000100, 1'b0, 1'b0));
  endtask

  task automatic tick();
    ent_t e;
    bit ev, pt, pd;
    e = '0; ev = 0; m_gt = 0; m_gd = 0;
    @(negedge clk);
    if (tx_en) begin
      if (cur.size() == 0) begin
        m_gt = tlp_req && (!dllp_req || (!PRIO && model_last));
        m_gd = dllp_req && !m_gt;
        if (m_gt) begin build_tlp(); model_last = 0; end
        if (m_gd) begin build_dllp(); model_last = 1; end
      end
      if (cur.size() != 0) begin e = cur.pop_front(); ev = 1; end
    end
    chk("tlp_gnt", tlp_gnt, m_gt);
    chk("dllp_gnt", dllp_gnt, m_gd);
    chk("tlp_rd", tlp_rd, e.rt);
    chk("dllp_rd", dllp_rd, e.rd);
    if (tlp_gnt) gq.push_back(1);
    if (dllp_gnt) gq.push_back(2);
    pt = tlp_rd; pd = dllp_rd;
    nrt += int'(pt); nrd += int'(pd);
    @(posedge clk); #1;
    chk("tx_valid", tx_valid, ev);
    chk("tx_sync", tx_sync, ev ? 2'b10 : 2'b00);
    chk("tx_type", tx_type, ev ? e.t : 6'b0);
    if (ev) chk("tx_data", tx_data, e.d);
    if (pt && tq.size() != 0) void'(tq.pop_front());
    if (pd && dq.size() != 0) void'(dq.pop_front());
    tlp_data = (tq.size() != 0) ? tq[0] : 8'h00;
    dllp_data = (dq.size() != 0) ? dq[0] : 8'h00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (cur.size() != 0 && n < 300) begin tick(); n++; end
    chk("drain_bound", cur.size(), 0);
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_sync"}, tx_sync, 0);
    chk({tag, "_tx_type"}, tx_type, 0);
    chk({tag, "_gnt"}, {tlp_gnt, dllp_gnt}, 0);
    chk({tag, "_rd"}, {tlp_rd, dllp_rd}, 0);
  endtask

  initial begin
    int exp_order[4];
    int n;
    rst = 0; tx_en = 0; tlp_req = 0; dllp_req = 0; tlp_bad = 0;
    tlp_len_dw = 0; tlp_seq = 0; tlp_data = 0; dllp_data = 0;
    model_last = 1; pay_fixed = 1; n_chk = 0; n_fail = 0;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1; rst = 1; tx_en = 1;
    tick();
    // directed TLP, len 2, seq 123, payload 01..08
    gq.delete(); nrt = 0;
    tlp_len_dw = 10'd2; tlp_seq = 12'h123; tlp_req = 1;
    tick(); tlp_req = 0;
    drain();
    chk("tlp_gnt_pulses", gq.size(), 1);
    chk("tlp_rd_count", nrt, 8);
    // DLLP alone
    gq.delete(); nrd = 0; pay_fixed = 0;
    dllp_req = 1;
    tick(); dllp_req = 0;
    drain();
    chk("dllp_gnt_pulses", gq.size(), 1);
    chk("dllp_rd_count", nrd, 8);
    // both requesters held: alternating grants (or DLLP-only with priority)
    gq.delete(); n = 0;
    tlp_len_dw = 10'($urandom_range(0, 2)); tlp_seq = 12'($urandom);
    tlp_req = 1; dllp_req = 1;
    while (gq.size() < 4 && n < 200) begin
      tick(); n++;
      if (m_gt) begin tlp_len_dw = 10'($urandom_range(0, 2)); tlp_seq = 12'($urandom); end
    end
    tlp_req = 0; dllp_req = 0;
    drain();
    for (int i = 0; i < 4; i++) exp_order[i] = PRIO ? 2 : ((i % 2 == 0) ? 1 : 2);
    for (int i = 0; i < 4; i++) chk($sformatf("grant_order%0d", i), (i < gq.size()) ? gq[i] : 0, exp_order[i]);
    // len 0 nullified TLP
    nrt = 0;
    tlp_len_dw = 0; tlp_seq = 12'($urandom); tlp_bad = 1; tlp_req = 1;
    tick(); tlp_req = 0;
    drain();
    chk("len0_rd_count", nrt, 0);
    tlp_bad = 0;
    // tx_en low for three cycles mid-payload
    nrt = 0;
    tlp_len_dw = 10'd3; tlp_seq = 12'($urandom); tlp_req = 1;
    tick(); tlp_req = 0;
    repeat (5) tick();
    tx_en = 0;
    repeat (3) tick();
    tx_en = 1;
    drain();
    chk("pause_rd_count", nrt, 12);
    // reset at payload byte 3, then a fresh TLP
    tlp_len_dw = 10'd2; tlp_seq = 12'($urandom); tlp_req = 1;
    tick(); tlp_req = 0;
    repeat (6) tick();
    rst = 0; #1;
    chk_zero("midrst");
    cur.delete(); tq.delete(); dq.delete(); tlp_data = 0; dllp_data = 0; model_last = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    tlp_seq = 12'($urandom); tlp_req = 1;
    tick(); tlp_req = 0;
    drain();
    // random traffic
    for (int c = 0; c < 600; c++) begin
      tx_en = ($urandom_range(0, 9) != 0);
      if (!tlp_req && $urandom_range(0, 3) == 0) begin
        tlp_req = 1; tlp_len_dw = 10'($urandom_range(0, 4)); tlp_seq = 12'($urandom);
      end
      if (!dllp_req && $urandom_range(0, 3) == 0) dllp_req = 1;
      tick();
      if (m_gt) tlp_req = 0;
      if (m_gd) dllp_req = 0;
      if (cur.size() == 0) tlp_bad = ($urandom_range(0, 3) == 0);
    end
    tx_en = 1; tlp_req = 0; dllp_req = 0;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
